// File: rtl/bpsk_pkg.sv
// Shared BPSK link constants: Barker sync word, frame geometry and the
// receive-side frame-sync state encoding. Usable by transmit and receive.
package bpsk_pkg;

    localparam int                    BARKER_LEN   = 7;
    localparam logic [BARKER_LEN-1:0] BARKER_DEF   = 7'b1110010;
    localparam int                    DATA_LEN_DEF = 50;
    localparam int                    MISS_MAX_DEF = 3;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_DATA   = 2'd1,
        ST_CHECK  = 2'd2
    } sync_state_t;

    // Number of window positions that agree with the sync word (0..7).
    function automatic logic [2:0] barker_matches(input logic [BARKER_LEN-1:0] win,
                                                  input logic [BARKER_LEN-1:0] sync_word);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < BARKER_LEN; i++) begin
            if (win[i] == sync_word[i]) begin
                cnt = cnt + 3'd1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/barker_corr.sv
// Seven-bit sliding window with combinational Barker match count. The count
// already includes the bit being accepted on the current edge.
module barker_corr
    import bpsk_pkg::*;
#(
    parameter logic [BARKER_LEN-1:0] BARKER = BARKER_DEF
) (
    input  logic       clk_sig,
    input  logic       reset_sig,
    input  logic       bit_sig,
    input  logic       vld,
    output logic [2:0] match_cnt
);

    logic [BARKER_LEN-1:0] window;
    logic [BARKER_LEN-1:0] window_nxt;

    assign window_nxt = {window[BARKER_LEN-2:0], bit_sig};
    assign match_cnt  = barker_matches(window_nxt, BARKER);

    always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            window <= '0;
        end else if (vld) begin
            window <= window_nxt;
        end
    end

endmodule

// File: rtl/rxd_frame_sync.sv
// Receive frame synchroniser: finds the Barker sync word in either carrier
// polarity, deframes coded bit pairs and flywheels through missed sync words.
module rxd_frame_sync
    import bpsk_pkg::*;
#(
    parameter logic [BARKER_LEN-1:0] BARKER   = BARKER_DEF,
    parameter int                    THRESH   = 6,
    parameter int                    DATA_LEN = DATA_LEN_DEF,
    parameter int                    MISS_MAX = MISS_MAX_DEF
) (
    input  logic        clk_sig,
    input  logic        reset_sig,
    input  logic        bit_sig,
    input  logic        bit_vld,
    output logic [1:0]  pair_sig,
    output logic        pair_vld,
    output logic        frame_start,
    output logic        lock_sig,
    output logic        inv_sig,
    output sync_state_t state_dbg
);

    localparam int BIT_W  = $clog2(DATA_LEN);
    localparam int MISS_W = $clog2(MISS_MAX + 1);

    localparam logic [BIT_W-1:0]  LAST_DATA  = BIT_W'(DATA_LEN - 1);
    localparam logic [BIT_W-1:0]  LAST_CHECK = BIT_W'(BARKER_LEN - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
    localparam logic [MISS_W-1:0] MISS_LIM   = MISS_W'(MISS_MAX);
    localparam logic [MISS_W-1:0] MISS_ONE   = MISS_W'(1);
    localparam logic [2:0]        NORM_MIN   = 3'(THRESH);
    localparam logic [2:0]        INV_MAX    = 3'(BARKER_LEN - THRESH);

    sync_state_t       state, state_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [MISS_W-1:0] miss_cnt, miss_nxt, miss_inc;
    logic              held, held_nxt;
    logic [1:0]        pair_sig_nxt;
    logic              pair_vld_nxt, frame_start_nxt, lock_nxt, inv_nxt;

    logic [2:0] match_cnt;
    logic       norm_hit, inv_hit, chk_hit, dat;

    barker_corr #(
        .BARKER (BARKER)
    ) u_corr (
        .clk_sig   (clk_sig),
        .reset_sig (reset_sig),
        .bit_sig   (bit_sig),
        .vld       (bit_vld),
        .match_cnt (match_cnt)
    );

    assign norm_hit  = (match_cnt >= NORM_MIN);
    assign inv_hit   = (match_cnt <= INV_MAX);
    // A sync check only succeeds in the polarity we locked on.
    assign chk_hit   = inv_sig ? inv_hit : norm_hit;
    assign dat       = bit_sig ^ inv_sig;
    assign miss_inc  = miss_cnt + MISS_ONE;
    assign state_dbg = state;

    always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state       <= ST_SEARCH;
            bit_cnt     <= '0;
            miss_cnt    <= '0;
            held        <= 1'b0;
            pair_sig    <= 2'b00;
            pair_vld    <= 1'b0;
            frame_start <= 1'b0;
            lock_sig    <= 1'b0;
            inv_sig     <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            miss_cnt    <= miss_nxt;
            held        <= held_nxt;
            pair_sig    <= pair_sig_nxt;
            pair_vld    <= pair_vld_nxt;
            frame_start <= frame_start_nxt;
            lock_sig    <= lock_nxt;
            inv_sig     <= inv_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        miss_nxt        = miss_cnt;
        held_nxt        = held;
        pair_sig_nxt    = pair_sig;
        pair_vld_nxt    = 1'b0;
        frame_start_nxt = 1'b0;
        lock_nxt        = lock_sig;
        inv_nxt         = inv_sig;
        if (bit_vld) begin
            unique case (state)
                ST_SEARCH: begin
                    if (norm_hit || inv_hit) begin
                        state_nxt       = ST_DATA;
                        lock_nxt        = 1'b1;
                        inv_nxt         = !norm_hit;
                        bit_cnt_nxt     = '0;
                        miss_nxt        = '0;
                        held_nxt        = 1'b0;
                        frame_start_nxt = 1'b1;
                    end
                end
                ST_DATA: begin
                    // Odd-index bits complete the pair started by the held bit.
                    if (bit_cnt[0]) begin
                        pair_sig_nxt = {held, dat};
                        pair_vld_nxt = 1'b1;
                    end else begin
                        held_nxt = dat;
                    end
                    if (bit_cnt == LAST_DATA) begin
                        state_nxt   = ST_CHECK;
                        bit_cnt_nxt = '0;
                        held_nxt    = 1'b0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_ONE;
                    end
                end
                ST_CHECK: begin
                    if (bit_cnt == LAST_CHECK) begin
                        bit_cnt_nxt = '0;
                        if (chk_hit) begin
                            state_nxt       = ST_DATA;
                            miss_nxt        = '0;
                            frame_start_nxt = 1'b1;
                        end else if (miss_inc == MISS_LIM) begin
                            state_nxt = ST_SEARCH;
                            miss_nxt  = '0;
                            lock_nxt  = 1'b0;
                            inv_nxt   = 1'b0;
                        end else begin
                            state_nxt = ST_DATA;
                            miss_nxt  = miss_inc;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rxd_frame_sync.sv
// Bench for rxd_frame_sync: scenario tasks drive bit streams, a frame-level
// reference model predicts every cycle's outputs, and each task checks them.
module tb_rxd_frame_sync;
    import bpsk_pkg::*;

    localparam int         THRESH   = 6;
    localparam int         DATA_LEN = 50;
    localparam int         MISS_MAX = 3;
    localparam logic [6:0] BARKER   = 7'b1110010;
    localparam int         W        = 6;

    // Six bits that walk the window from all-zero without ever nearing a hit.
    localparam logic [31:0] SAFE_PREFIX = 32'b100010;
    localparam logic [31:0] SYNC_WORD   = 32'b1110010;
    localparam logic [31:0] SYNC_INV    = 32'b0001101;
    localparam logic [31:0] ONE_FLIP    = 32'b1110110;
    localparam logic [31:0] TWO_FLIP    = 32'b1100110;

    logic        clk_sig = 1'b0;
    logic        reset_sig;
    logic        bit_sig;
    logic        bit_vld;
    logic [1:0]  pair_sig;
    logic        pair_vld;
    logic        frame_start;
    logic        lock_sig;
    logic        inv_sig;
    sync_state_t state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    logic [1:0]   pair_q[$];
    int           obs_pv_cnt;
    int           obs_fs_cnt;

    // Reference model state: frame position rather than FSM states.
    int         m_win;
    logic       m_locked;
    logic       m_inv;
    int         m_pos;
    int         m_miss;
    logic       m_held;
    logic [1:0] m_ps;
    logic       m_pv;
    logic       m_fs;

    rxd_frame_sync #(
        .BARKER   (BARKER),
        .THRESH   (THRESH),
        .DATA_LEN (DATA_LEN),
        .MISS_MAX (MISS_MAX)
    ) dut (
        .clk_sig     (clk_sig),
        .reset_sig   (reset_sig),
        .bit_sig     (bit_sig),
        .bit_vld     (bit_vld),
        .pair_sig    (pair_sig),
        .pair_vld    (pair_vld),
        .frame_start (frame_start),
        .lock_sig    (lock_sig),
        .inv_sig     (inv_sig),
        .state_dbg   (state_dbg)
    );

    always #5 clk_sig = ~clk_sig;

    task automatic model_reset;
        m_win = 0; m_locked = 1'b0; m_inv = 1'b0; m_pos = 0; m_miss = 0;
        m_held = 1'b0; m_ps = 2'b00; m_pv = 1'b0; m_fs = 1'b0;
    endtask

    task automatic model_step(input logic b);
        int   m;
        logic d;
        logic good;
        m_win = ((m_win << 1) | int'(b)) & 127;
        m = 7 - $countones(m_win ^ int'(BARKER));
        m_pv = 1'b0;
        m_fs = 1'b0;
        if (!m_locked) begin
            if (m >= THRESH || m <= 7 - THRESH) begin
                m_locked = 1'b1;
                m_inv    = (m < THRESH);
                m_pos    = 0;
                m_miss   = 0;
                m_fs     = 1'b1;
            end
        end else if (m_pos < DATA_LEN) begin
            d = b ^ m_inv;
            if (m_pos % 2 == 0) m_held = d;
            else begin
                m_pv = 1'b1;
                m_ps = {m_held, d};
            end
            m_pos++;
        end else begin
            m_pos++;
            if (m_pos == DATA_LEN + 7) begin
                good  = m_inv ? (m <= 7 - THRESH) : (m >= THRESH);
                m_pos = 0;
                if (good) begin
                    m_fs   = 1'b1;
                    m_miss = 0;
                end else begin
                    m_miss++;
                    if (m_miss == MISS_MAX) begin
                        m_locked = 1'b0;
                        m_inv    = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic clear_obs;
        obs_pv_cnt = 0;
        obs_fs_cnt = 0;
        pair_q.delete();
    endtask

    task automatic drive_bit(input logic b, input logic v);
        bit_sig = b;
        bit_vld = v;
        @(posedge clk_sig);
        if (v) model_step(b);
        else begin
            m_pv = 1'b0;
            m_fs = 1'b0;
        end
        exp_q.push_back({m_pv, m_ps, m_fs, m_locked, m_inv});
        #1;
        obs_q.push_back({pair_vld, pair_sig, frame_start, lock_sig, inv_sig});
        if (pair_vld) begin
            obs_pv_cnt++;
            pair_q.push_back(pair_sig);
        end
        if (frame_start) obs_fs_cnt++;
        bit_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic send_bits(input logic [31:0] pat, input int n, input int gmin, input int gmax);
        for (int i = n - 1; i >= 0; i--) begin
            drive_bit(pat[i], 1'b1);
            idle($urandom_range(gmax, gmin));
        end
    endtask

    task automatic send_rand(input int n, input int gmin, input int gmax);
        for (int i = 0; i < n; i++) begin
            drive_bit(1'($urandom_range(0, 1)), 1'b1);
            idle($urandom_range(gmax, gmin));
        end
    endtask

    task automatic do_reset;
        bit_vld   = 1'b0;
        bit_sig   = 1'b0;
        reset_sig = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_sig);
        #1;
        reset_sig = 1'b0;
        exp_q.delete();
        obs_q.delete();
        clear_obs();
    endtask

    task automatic test_reset;
        bit_vld   = 1'b0;
        bit_sig   = 1'b0;
        reset_sig = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_sig);
        #1;
        checks++; if (pair_sig !== 2'b00) begin failures++; $display("FAIL reset_pair_sig got=%b want=00", pair_sig); end
        checks++; if (pair_vld !== 1'b0) begin failures++; $display("FAIL reset_pair_vld got=%b want=0", pair_vld); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start got=%b want=0", frame_start); end
        checks++; if (lock_sig !== 1'b0) begin failures++; $display("FAIL reset_lock got=%b want=0", lock_sig); end
        checks++; if (inv_sig !== 1'b0) begin failures++; $display("FAIL reset_inv got=%b want=0", inv_sig); end
        checks++; if (state_dbg !== ST_SEARCH) begin failures++; $display("FAIL reset_state got=%0d want=%0d", state_dbg, ST_SEARCH); end
        reset_sig = 1'b0;
        exp_q.delete();
        obs_q.delete();
        clear_obs();
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] e, o;
        int bad;
        do_reset();
        send_bits(SYNC_WORD, 7, 0, 0);
        for (int i = 0; i < DATA_LEN; i++) drive_bit(logic'(i % 2 == 0), 1'b1);
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL b2b_cycle got=%b want=%b", o, e); end
        end
        bad = 0;
        foreach (pair_q[i]) if (pair_q[i] !== 2'b10) bad++;
        checks++; if (obs_fs_cnt != 1) begin failures++; $display("FAIL b2b_frame_starts got=%0d want=1", obs_fs_cnt); end
        checks++; if (obs_pv_cnt != 25) begin failures++; $display("FAIL b2b_pairs got=%0d want=25", obs_pv_cnt); end
        checks++; if (bad != 0) begin failures++; $display("FAIL b2b_pair_value bad=%0d want=0", bad); end
        checks++; if (lock_sig !== 1'b1) begin failures++; $display("FAIL b2b_lock got=%b want=1", lock_sig); end
        checks++; if (inv_sig !== 1'b0) begin failures++; $display("FAIL b2b_inv got=%b want=0", inv_sig); end
    endtask

    task automatic test_inverted;
        logic [W-1:0] e, o;
        int bad;
        do_reset();
        send_bits(SYNC_INV, 7, 0, 0);
        for (int i = 0; i < DATA_LEN; i++) drive_bit(1'b0, 1'b1);
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL inv_cycle got=%b want=%b", o, e); end
        end
        bad = 0;
        foreach (pair_q[i]) if (pair_q[i] !== 2'b11) bad++;
        checks++; if (obs_fs_cnt != 1) begin failures++; $display("FAIL inv_frame_starts got=%0d want=1", obs_fs_cnt); end
        checks++; if (obs_pv_cnt != 25) begin failures++; $display("FAIL inv_pairs got=%0d want=25", obs_pv_cnt); end
        checks++; if (bad != 0) begin failures++; $display("FAIL inv_pair_value bad=%0d want=0", bad); end
        checks++; if (inv_sig !== 1'b1) begin failures++; $display("FAIL inv_flag got=%b want=1", inv_sig); end
        checks++; if (lock_sig !== 1'b1) begin failures++; $display("FAIL inv_lock got=%b want=1", lock_sig); end
    endtask

    task automatic test_threshold;
        logic [W-1:0] e, o;
        do_reset();
        send_bits(SAFE_PREFIX, 6, 0, 1);
        send_bits(ONE_FLIP, 7, 0, 1);
        checks++; if (lock_sig !== 1'b1) begin failures++; $display("FAIL thr_one_flip_lock got=%b want=1", lock_sig); end
        checks++; if (obs_fs_cnt != 1) begin failures++; $display("FAIL thr_one_flip_fs got=%0d want=1", obs_fs_cnt); end
        send_rand(DATA_LEN, 0, 1);
        checks++; if (obs_pv_cnt != 25) begin failures++; $display("FAIL thr_one_flip_pairs got=%0d want=25", obs_pv_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL thr1_cycle got=%b want=%b", o, e); end
        end
        do_reset();
        send_bits(SAFE_PREFIX, 6, 0, 1);
        send_bits(TWO_FLIP, 7, 0, 1);
        idle(10);
        checks++; if (lock_sig !== 1'b0) begin failures++; $display("FAIL thr_two_flip_lock got=%b want=0", lock_sig); end
        checks++; if (obs_pv_cnt != 0) begin failures++; $display("FAIL thr_two_flip_pairs got=%0d want=0", obs_pv_cnt); end
        checks++; if (obs_fs_cnt != 0) begin failures++; $display("FAIL thr_two_flip_fs got=%0d want=0", obs_fs_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL thr2_cycle got=%b want=%b", o, e); end
        end
    endtask

    task automatic test_flywheel;
        logic [W-1:0] e, o;
        do_reset();
        send_bits(SYNC_WORD, 7, 0, 0);
        send_rand(DATA_LEN, 0, 0);
        clear_obs();
        send_bits(TWO_FLIP, 7, 0, 0);
        send_rand(DATA_LEN, 0, 0);
        send_bits(TWO_FLIP, 7, 0, 0);
        send_rand(DATA_LEN, 0, 0);
        checks++; if (lock_sig !== 1'b1) begin failures++; $display("FAIL fly_lock_held got=%b want=1", lock_sig); end
        send_bits(TWO_FLIP, 7, 0, 0);
        checks++; if (lock_sig !== 1'b0) begin failures++; $display("FAIL fly_lock_drop got=%b want=0", lock_sig); end
        checks++; if (inv_sig !== 1'b0) begin failures++; $display("FAIL fly_inv got=%b want=0", inv_sig); end
        checks++; if (obs_fs_cnt != 0) begin failures++; $display("FAIL fly_frame_starts got=%0d want=0", obs_fs_cnt); end
        checks++; if (obs_pv_cnt != 50) begin failures++; $display("FAIL fly_pairs got=%0d want=50", obs_pv_cnt); end
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL fly_cycle got=%b want=%b", o, e); end
        end
    endtask

    task automatic test_rate_reset;
        logic [W-1:0] e, o;
        do_reset();
        send_bits(SYNC_WORD, 7, 4, 4);
        send_rand(20, 4, 4);
        checks++; if (obs_fs_cnt != 1) begin failures++; $display("FAIL rate_frame_starts got=%0d want=1", obs_fs_cnt); end
        checks++; if (obs_pv_cnt != 10) begin failures++; $display("FAIL rate_pairs got=%0d want=10", obs_pv_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL rate_cycle got=%b want=%b", o, e); end
        end
        #3;
        reset_sig = 1'b1;
        #1;
        checks++; if ({pair_sig, pair_vld, frame_start, lock_sig, inv_sig} !== 6'b0) begin
            failures++;
            $display("FAIL rate_async_reset got=%b want=000000",
                     {pair_sig, pair_vld, frame_start, lock_sig, inv_sig});
        end
        checks++; if (state_dbg !== ST_SEARCH) begin failures++; $display("FAIL rate_reset_state got=%0d want=%0d", state_dbg, ST_SEARCH); end
        model_reset();
        @(posedge clk_sig);
        #1;
        reset_sig = 1'b0;
        clear_obs();
        send_bits(SAFE_PREFIX, 6, 4, 4);
        checks++; if (lock_sig !== 1'b0) begin failures++; $display("FAIL rate_early_lock got=%b want=0", lock_sig); end
        checks++; if (obs_pv_cnt != 0) begin failures++; $display("FAIL rate_early_pairs got=%0d want=0", obs_pv_cnt); end
        send_bits(SYNC_WORD, 7, 4, 4);
        send_rand(10, 4, 4);
        checks++; if (obs_fs_cnt != 1) begin failures++; $display("FAIL rate_relock_fs got=%0d want=1", obs_fs_cnt); end
        checks++; if (obs_pv_cnt != 5) begin failures++; $display("FAIL rate_relock_pairs got=%0d want=5", obs_pv_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL relock_cycle got=%b want=%b", o, e); end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] e, o;
        logic [31:0]  word;
        int           kind;
        do_reset();
        send_bits(($urandom_range(0, 1) == 1) ? SYNC_INV : SYNC_WORD, 7, 0, 2);
        for (int f = 0; f < 10; f++) begin
            send_rand(DATA_LEN, 0, 2);
            kind = $urandom_range(0, 3);
            case (kind)
                0:       word = m_inv ? SYNC_INV : SYNC_WORD;
                1:       word = (m_inv ? SYNC_INV : SYNC_WORD) ^ (32'd1 << $urandom_range(0, 6));
                2:       word = 32'($urandom_range(0, 127));
                default: word = m_inv ? SYNC_WORD : SYNC_INV;
            endcase
            send_bits(word, 7, 0, 2);
        end
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL rand_cycle got=%b want=%b", o, e); end
        end
    endtask

    initial begin
        reset_sig = 1'b1;
        bit_sig   = 1'b0;
        bit_vld   = 1'b0;
        test_reset();
        test_back_to_back();
        test_inverted();
        test_threshold();
        test_flywheel();
        test_rate_reset();
        for (int r = 0; r < 3; r++) test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rxd_frame_sync.md
RXD_FRAME_SYNC -- requirements
Module: rxd_frame_sync

Interface
REQ-001 SHALL have parameter BARKER, default 7'b1110010, the sync word; MSB is sent first.
REQ-002 SHALL have parameter THRESH, default 6, the minimum Barker bit matches (0..7) that count as a detection.
REQ-003 SHALL have parameter DATA_LEN, default 50, the coded bits per frame after the sync word; it SHALL be even.
REQ-004 SHALL have parameter MISS_MAX, default 3, the consecutive failed sync checks before lock is dropped.
REQ-005 SHALL have one clock and asynchronous active-high reset: clk_sig input 1 (all state changes on its rising edge); reset_sig input 1 (active-high, asynchronous).
REQ-006 SHALL have input bit_sig, 1 bit: hard-decision demodulated symbol.
REQ-007 SHALL have input bit_vld, 1 bit: bit_sig is accepted on a clock edge where bit_vld=1.
REQ-008 SHALL have output pair_sig, 2 bits: coded pair; [1] is the first-received bit.
REQ-009 SHALL have output pair_vld, 1 bit: one-cycle strobe qualifying pair_sig.
REQ-010 SHALL have output frame_start, 1 bit: one-cycle pulse on each accepted sync word.
REQ-011 SHALL have output lock_sig, 1 bit: high while frame-locked.
REQ-012 SHALL have output inv_sig, 1 bit: high when the carrier phase is inverted (180 deg ambiguity).

Function
REQ-013 SHALL shift accepted bits into a 7-bit window, newest in the LSB; the match count is the number of window bits equal to BARKER, including the bit accepted on that edge.
REQ-014 SHALL declare a normal hit when matches >= THRESH, and an inverted hit when matches <= 7-THRESH.
REQ-015 SHALL implement FSM states SEARCH, DATA and CHECK; the reset state is SEARCH.
REQ-016 SEARCH: on the edge that accepts a bit giving a normal or inverted hit, go to DATA, set lock_sig=1, set inv_sig=0 or 1 respectively, clear the bit counter and miss counter, and pulse frame_start on the next cycle.
REQ-017 DATA: XOR each accepted bit with inv_sig; even-index bits are held, odd-index bits complete a pair; pair_vld pulses exactly one cycle after the edge accepting the odd bit; after DATA_LEN bits go to CHECK.
REQ-018 CHECK: accept exactly 7 bits, then evaluate the window against the polarity held in inv_sig (an opposite-polarity hit counts as a miss).
REQ-019 On a CHECK hit: pulse frame_start, clear the miss counter, enter DATA.
REQ-020 On a CHECK miss: increment the miss counter; if it reaches MISS_MAX, clear lock_sig and inv_sig and enter SEARCH; otherwise enter DATA (flywheel) without pulsing frame_start.
REQ-021 SHALL ignore cycles with bit_vld=0 in every state; counters and the window SHALL hold.
REQ-022 SHALL never emit pair_vld in SEARCH or CHECK; a partial pair SHALL be discarded on any transition out of DATA.
REQ-023 Back-to-back bit_vld (every cycle) SHALL be sustained with no bit loss.
REQ-024 The match count SHALL be a 3-bit unsigned value computed combinationally; no other arithmetic exceeds the counter widths, which are clog2(DATA_LEN) for bits and clog2(MISS_MAX+1) for misses.

Reset
REQ-025 While reset_sig=1: state=SEARCH; window, counters and held bit =0; pair_sig=2'b00, pair_vld=0, frame_start=0, lock_sig=0, inv_sig=0.
REQ-026 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL require a fresh sync word before any pair_vld.

Structure
REQ-027 BARKER default, state encoding and frame-length constants SHALL live in a shared package (bpsk_pkg) that is also usable by the transmit side.
REQ-028 The window plus match-count logic SHALL be one sub-module, barker_corr (inputs bit, vld; outputs match count); the FSM and deframing SHALL stay in rxd_frame_sync.

Verification
REQ-029 The bench SHALL send 1110010 followed by 50 alternating bits 1,0,1,0..., with vld every cycle. Required response: frame_start once; lock_sig=1, inv_sig=0; 25 pair_vld with pair_sig=2'b10.
REQ-030 The bench SHALL send the inverted preamble 0001101 followed by 50 zeros. Required response: inv_sig=1; 25 pairs of 2'b11.
REQ-031 The bench SHALL send a preamble with one bit flipped (1110110) and THRESH=6. Required response: lock. With two flips (1100110): no lock, no pair_vld.
REQ-032 The bench SHALL lock, then send 3 frames with corrupted sync words. Required response: pairs continue through frames 1-2; lock_sig drops after the 3rd check; no frame_start during these frames.
REQ-033 The bench SHALL drive bit_vld at 1-in-5 cycles, matching the 2 MHz rate on a 10 MHz clock, and assert reset_sig at data bit 20. Required response: all outputs 0 immediately; relock only on the next full sync word.
